// File: rtl/softex_slot_regfile.sv
// State-slot store for softex: keeps per-row running max/denominator so rows can be
// suspended and resumed. Requests (ALLOC/LOAD) answer through one registered response.
module softex_slot_regfile #(
   parameter int unsigned          N_SLOTS   = 4,
   parameter int unsigned          ADDR_W    = 8,
   parameter int unsigned          WIDTH_IN  = 16,
   parameter int unsigned          WIDTH_ACC = 32,
   parameter logic [WIDTH_IN-1:0]  MAX_RESET = 16'hFF80
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic                           req_op_i,
   input  logic [ADDR_W-1:0]              req_addr_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [ADDR_W-1:0]              rsp_addr_o,
   output logic [WIDTH_IN-1:0]            rsp_maximum_o,
   output logic [WIDTH_ACC-1:0]           rsp_denominator_o,
   output logic                           rsp_error_o,
   input  logic                           upd_valid_i,
   input  logic                           upd_op_i,
   input  logic [ADDR_W-1:0]              upd_addr_i,
   input  logic [WIDTH_IN-1:0]            upd_maximum_i,
   input  logic [WIDTH_ACC-1:0]           upd_denominator_i,
   output logic [$clog2(N_SLOTS+1)-1:0]   free_count_o
);

   localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);

   typedef struct packed {
      logic [WIDTH_IN-1:0]  maximum;
      logic [WIDTH_ACC-1:0] denominator;
      logic                 valid;
   } slot_t;

   localparam slot_t FREE_SLOT  = '{maximum: MAX_RESET, denominator: '0, valid: 1'b0};
   localparam slot_t ALLOC_SLOT = '{maximum: MAX_RESET, denominator: '0, valid: 1'b1};

   slot_t                slot_q [N_SLOTS];
   slot_t                slot_d [N_SLOTS];
   logic                 rsp_valid_q, rsp_valid_d;
   logic [ADDR_W-1:0]    rsp_addr_q, rsp_addr_d;
   logic [WIDTH_IN-1:0]  rsp_max_q, rsp_max_d;
   logic [WIDTH_ACC-1:0] rsp_den_q, rsp_den_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]     free_count_q, free_count_d;

   logic                 req_fire;
   logic                 alloc_found;
   int unsigned          alloc_idx;
   logic                 load_hit;
   slot_t                load_slot;

   assign req_ready_o = !clear_i && (!rsp_valid_q || rsp_ready_i);
   assign req_fire    = req_valid_i && req_ready_o;

   // Requests and updates both see the pre-edge slot state; no forwarding.
   always_comb begin
      slot_d       = slot_q;
      rsp_valid_d  = rsp_valid_q && !rsp_ready_i;
      rsp_addr_d   = rsp_addr_q;
      rsp_max_d    = rsp_max_q;
      rsp_den_d    = rsp_den_q;
      rsp_err_d    = rsp_err_q;
      alloc_found  = 1'b0;
      alloc_idx    = 0;
      load_hit     = 1'b0;
      load_slot    = '0;
      free_count_d = '0;

      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (!slot_q[i].valid && !alloc_found) begin
            alloc_found = 1'b1;
            alloc_idx   = i;
         end
         if (32'(req_addr_i) == i && slot_q[i].valid) begin
            load_hit  = 1'b1;
            load_slot = slot_q[i];
         end
      end

      // Out-of-range addresses never match a slot, so those updates drop.
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (upd_valid_i && 32'(upd_addr_i) == i && slot_q[i].valid) begin
            if (upd_op_i) begin
               slot_d[i] = FREE_SLOT;
            end else begin
               slot_d[i].maximum     = upd_maximum_i;
               slot_d[i].denominator = upd_denominator_i;
            end
         end
      end

      if (req_fire) begin
         rsp_valid_d = 1'b1;
         if (!req_op_i) begin
            if (alloc_found) begin
               for (int unsigned i = 0; i < N_SLOTS; i++) begin
                  if (alloc_idx == i) slot_d[i] = ALLOC_SLOT;
               end
               rsp_addr_d = ADDR_W'(alloc_idx);
               rsp_max_d  = MAX_RESET;
               rsp_den_d  = '0;
               rsp_err_d  = 1'b0;
            end else begin
               rsp_addr_d = '0;
               rsp_max_d  = '0;
               rsp_den_d  = '0;
               rsp_err_d  = 1'b1;
            end
         end else begin
            rsp_addr_d = req_addr_i;
            rsp_max_d  = load_hit ? load_slot.maximum : '0;
            rsp_den_d  = load_hit ? load_slot.denominator : '0;
            rsp_err_d  = !load_hit;
         end
      end

      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (!slot_d[i].valid) free_count_d = free_count_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         for (int unsigned i = 0; i < N_SLOTS; i++) slot_q[i] <= FREE_SLOT;
         rsp_valid_q  <= 1'b0;
         rsp_addr_q   <= '0;
         rsp_max_q    <= '0;
         rsp_den_q    <= '0;
         rsp_err_q    <= 1'b0;
         free_count_q <= CNT_W'(N_SLOTS);
      end else begin
         for (int unsigned i = 0; i < N_SLOTS; i++) slot_q[i] <= slot_d[i];
         rsp_valid_q  <= rsp_valid_d;
         rsp_addr_q   <= rsp_addr_d;
         rsp_max_q    <= rsp_max_d;
         rsp_den_q    <= rsp_den_d;
         rsp_err_q    <= rsp_err_d;
         free_count_q <= free_count_d;
      end
   end

   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_addr_o        = rsp_addr_q;
   assign rsp_maximum_o     = rsp_max_q;
   assign rsp_denominator_o = rsp_den_q;
   assign rsp_error_o       = rsp_err_q;
   assign free_count_o      = free_count_q;

endmodule
